// File: rtl/acc_result_reader.sv
// Consumer of completed neuron sums: emits a ReLU/shift/saturate activation per
// sample and reports the argmax class index and score once per layer pass.
module acc_result_reader #(
    parameter int DIN_W       = 22,
    parameter int NUM_NEURONS = 10,
    parameter int OUT_W       = 8,
    parameter int SHIFT       = 7,
    parameter int IDX_W       = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    acc_valid,
    input  logic signed [DIN_W-1:0] acc_data,
    output logic                    act_valid,
    output logic [OUT_W-1:0]        act_data,
    output logic                    busy,
    output logic                    done,
    output logic [IDX_W-1:0]        class_idx,
    output logic signed [DIN_W-1:0] class_score
);

    typedef enum logic [1:0] {IDLE, COLLECT, DONE} state_t;

    localparam int                      ACT_MAX_INT = (1 << (OUT_W - 1)) - 1;
    localparam logic signed [DIN_W-1:0] ACT_MAX     = DIN_W'(ACT_MAX_INT);
    localparam logic [IDX_W-1:0]        LAST_IDX    = IDX_W'(NUM_NEURONS - 1);

    state_t                  state_q, state_d;
    logic [IDX_W-1:0]        count_q, count_d;
    logic                    first_q, first_d;
    logic signed [DIN_W-1:0] max_q, max_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic                    act_valid_q, act_valid_d;
    logic [OUT_W-1:0]        act_data_q, act_data_d;
    logic [IDX_W-1:0]        class_idx_q, class_idx_d;
    logic signed [DIN_W-1:0] class_score_q, class_score_d;

    logic                    accept;
    logic signed [DIN_W-1:0] shifted;
    logic [OUT_W-1:0]        act_val;

    assign accept  = (state_q == COLLECT) && acc_valid;
    assign shifted = acc_data >>> SHIFT;

    // Negative sums clamp to zero; positive sums saturate at the largest signed OUT_W value.
    always_comb begin
        act_val = '0;
        if (!acc_data[DIN_W-1]) begin
            if (shifted > ACT_MAX) act_val = ACT_MAX[OUT_W-1:0];
            else                   act_val = shifted[OUT_W-1:0];
        end
    end

    always_comb begin
        state_d       = state_q;
        count_d       = count_q;
        first_d       = first_q;
        max_d         = max_q;
        idx_d         = idx_q;
        act_valid_d   = accept;
        act_data_d    = act_data_q;
        class_idx_d   = class_idx_q;
        class_score_d = class_score_q;

        if (accept) begin
            act_data_d = act_val;
            count_d    = count_q + 1'b1;
            first_d    = 1'b0;
            if (first_q) begin
                max_d = acc_data;
                idx_d = '0;
            end else if (acc_data > max_q) begin
                max_d = acc_data;
                idx_d = count_q;
            end
        end

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = COLLECT;
                    count_d = '0;
                    first_d = 1'b1;
                end
            end
            COLLECT: begin
                // Publish the result on the same edge that enters DONE, including the final sample.
                if (accept && count_q == LAST_IDX) begin
                    state_d       = DONE;
                    class_idx_d   = idx_d;
                    class_score_d = max_d;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= IDLE;
            count_q       <= '0;
            first_q       <= 1'b0;
            max_q         <= '0;
            idx_q         <= '0;
            act_valid_q   <= 1'b0;
            act_data_q    <= '0;
            class_idx_q   <= '0;
            class_score_q <= '0;
        end else begin
            state_q       <= state_d;
            count_q       <= count_d;
            first_q       <= first_d;
            max_q         <= max_d;
            idx_q         <= idx_d;
            act_valid_q   <= act_valid_d;
            act_data_q    <= act_data_d;
            class_idx_q   <= class_idx_d;
            class_score_q <= class_score_d;
        end
    end

    assign act_valid   = act_valid_q;
    assign act_data    = act_data_q;
    assign busy        = (state_q != IDLE);
    assign done        = (state_q == DONE);
    assign class_idx   = class_idx_q;
    assign class_score = class_score_q;

endmodule

// File: tb/tb_acc_result_reader.sv
// Directed self-checking bench for acc_result_reader: activation mapping,
// argmax with ties, negative sums, gapped valids, and reset mid-pass.
module tb_acc_result_reader;

    logic               clk;
    logic               rst;
    logic               start;
    logic               acc_valid;
    logic signed [21:0] acc_data;
    logic               act_valid;
    logic [7:0]         act_data;
    logic               busy;
    logic               done;
    logic [3:0]         class_idx;
    logic signed [21:0] class_score;

    int total = 0;
    int bad   = 0;

    acc_result_reader dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .acc_valid  (acc_valid),
        .acc_data   (acc_data),
        .act_valid  (act_valid),
        .act_data   (act_data),
        .busy       (busy),
        .done       (done),
        .class_idx  (class_idx),
        .class_score(class_score)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Every comparison funnels through here so the counts stay honest.
    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got=%0d expected=%0d", tag, $signed(got), $signed(exp));
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic startPass();
        start = 1'b1;
        tick();
        start = 1'b0;
        checkOutput("busy_after_start", 32'(busy), 32'd1);
    endtask

    // Presents one sample, then checks the registered activation and the done flag.
    task automatic applyStimulus(input int d, input int expAct, input bit isLast);
        acc_valid = 1'b1;
        acc_data  = 22'(d);
        tick();
        acc_valid = 1'b0;
        checkOutput("act_valid", 32'(act_valid), 32'd1);
        checkOutput("act_data", 32'(act_data), 32'(expAct));
        checkOutput("done_flag", 32'(done), 32'(isLast));
    endtask

    task automatic runPass(input int sums[10], input int acts[10], input int gapped,
                           input int expIdx, input int expScore, input string name);
        startPass();
        for (int i = 0; i < 10; i++) begin
            if (gapped != 0) begin
                for (int g = 0; g < (i % 4); g++) begin
                    if (i == 5 && g == 0) start = 1'b1;
                    tick();
                    start = 1'b0;
                    checkOutput("busy_in_gap", 32'(busy), 32'd1);
                    checkOutput("no_act_in_gap", 32'(act_valid), 32'd0);
                end
            end
            applyStimulus(sums[i], acts[i], i == 9);
        end
        checkOutput({name, "_idx"}, 32'(class_idx), 32'(expIdx));
        checkOutput({name, "_score"}, 32'(class_score), 32'(expScore));
        checkOutput({name, "_busy_in_done"}, 32'(busy), 32'd1);
    endtask

    int actSums[10]  = '{-500, 0, 127, 128, 16383, 16384, 2097151, 0, 0, 0};
    int actExp[10]   = '{0, 0, 0, 1, 127, 127, 127, 0, 0, 0};
    int tieSums[10]  = '{5, -3, 900, 12, 900, -1, 0, 899, 7, 2};
    int tieActs[10]  = '{0, 0, 7, 0, 7, 0, 0, 7, 0, 0};
    int negSums[10]  = '{-10, -4, -9, -4, -20, -30, -5, -6, -7, -8};
    int zeroActs[10] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0};

    initial begin
        rst       = 1'b0;
        start     = 1'b0;
        acc_valid = 1'b0;
        acc_data  = '0;
        tick(); tick(); tick();
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_done", 32'(done), 32'd0);
        checkOutput("rst_act_valid", 32'(act_valid), 32'd0);
        checkOutput("rst_act_data", 32'(act_data), 32'd0);
        checkOutput("rst_idx", 32'(class_idx), 32'd0);
        checkOutput("rst_score", 32'(class_score), 32'd0);
        rst = 1'b1;
        tick();

        // Valid samples without a start must be ignored.
        for (int i = 0; i < 3; i++) begin
            acc_valid = 1'b1;
            acc_data  = 22'(1000 + i);
            tick();
            checkOutput("idle_no_act", 32'(act_valid), 32'd0);
            checkOutput("idle_busy", 32'(busy), 32'd0);
        end
        acc_valid = 1'b0;
        checkOutput("idle_act_data", 32'(act_data), 32'd0);

        runPass(actSums, actExp, 0, 6, 2097151, "act_pass");
        tick();
        checkOutput("act_pass_done_clear", 32'(done), 32'd0);
        checkOutput("act_pass_idle", 32'(busy), 32'd0);
        checkOutput("act_data_hold", 32'(act_data), 32'd0);

        runPass(tieSums, tieActs, 0, 2, 900, "tie");
        tick();
        checkOutput("tie_done_clear", 32'(done), 32'd0);

        // Results from the previous pass hold across the next start.
        startPass();
        checkOutput("hold_idx", 32'(class_idx), 32'd2);
        checkOutput("hold_score", 32'(class_score), 32'd900);
        for (int i = 0; i < 10; i++) applyStimulus(negSums[i], 0, i == 9);
        checkOutput("neg_idx", 32'(class_idx), 32'd1);
        checkOutput("neg_score", 32'(class_score), 32'(-4));

        // In the DONE cycle both start and acc_valid must be ignored.
        start     = 1'b1;
        acc_valid = 1'b1;
        acc_data  = 22'd5000;
        tick();
        start     = 1'b0;
        acc_valid = 1'b0;
        checkOutput("done_start_ignored", 32'(busy), 32'd0);
        checkOutput("done_valid_ignored", 32'(act_valid), 32'd0);

        // Start in the first IDLE cycle after DONE is honoured.
        runPass(tieSums, tieActs, 1, 2, 900, "gapped");
        tick();
        checkOutput("gapped_busy_after", 32'(busy), 32'd0);

        // Abandon a pass with reset; outputs clear without a clock edge.
        startPass();
        for (int i = 0; i < 4; i++) applyStimulus(5000, 39, 1'b0);
        #2;
        rst = 1'b0;
        #1;
        checkOutput("async_idx", 32'(class_idx), 32'd0);
        checkOutput("async_score", 32'(class_score), 32'd0);
        checkOutput("async_busy", 32'(busy), 32'd0);
        checkOutput("async_act_valid", 32'(act_valid), 32'd0);
        tick();
        rst = 1'b1;
        tick();
        runPass(negSums, zeroActs, 0, 1, -4, "fresh");
        tick();
        checkOutput("fresh_done_clear", 32'(done), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/acc_result_reader.md
Name: acc_result_reader

Overview:
- Consumer end of the neuron accumulator output interface: reads 22-bit signed neuron sums as each neuron's accumulation completes.
- Produces a ReLU-activated, scaled, saturated 8-bit activation stream for the next layer.
- Tracks the argmax over one layer's NUM_NEURONS outputs and reports the winning class index (digit) and its score.

Parameters:
- DIN_W, 22, width of the signed accumulator sum.
- NUM_NEURONS, 10, neuron outputs per layer pass.
- OUT_W, 8, activation output width; values are unsigned, 0..2^(OUT_W-1)-1.
- SHIFT, 7, arithmetic right shift applied before saturation.
- IDX_W, 4, width of the neuron index; must satisfy 2^IDX_W >= NUM_NEURONS.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse that begins a layer pass.
- acc_valid  in  1  acc_data holds a completed neuron sum this cycle.
- acc_data  in  DIN_W  signed two's-complement neuron sum.
- act_valid  out  1  act_data valid this cycle.
- act_data  out  OUT_W  activation: ReLU, then shift, then saturate.
- busy  out  1  high while collecting a pass.
- done  out  1  one-cycle pulse when the pass completes.
- class_idx  out  IDX_W  index of the maximum sum in the last completed pass.
- class_score  out  DIN_W  signed maximum sum of the last completed pass.

Behaviour:
- Reset (rst=0, asynchronous): all outputs are 0, state=IDLE, count=0, internal max=0.
- FSM states: IDLE, COLLECT, DONE.
  - IDLE: start=1 -> COLLECT; count cleared to 0; first-sample flag set.
  - COLLECT: a sample is accepted on every cycle with acc_valid=1. When the accepted sample has count==NUM_NEURONS-1 -> DONE.
  - DONE: done=1 for exactly one cycle, then -> IDLE unconditionally.
- busy = 1 in COLLECT and DONE; 0 in IDLE.
- start is ignored in COLLECT and DONE.
- acc_valid is ignored in IDLE and DONE: no act_valid is produced and the argmax is not updated.
- Activation path (accepted samples only), registered, latency 1 cycle:
  - act_valid is high in the cycle after acceptance.
  - acc_data < 0 -> act_data = 0.
  - otherwise s = acc_data >> SHIFT; act_data = min(s, 2^(OUT_W-1)-1), which is 127 at defaults.
  - act_data is unchanged when act_valid=0.
- Argmax, on each accepted sample:
  - The first sample of a pass always loads max=acc_data and idx=0.
  - Later samples: load max and idx=count only if acc_data > max (signed, strict). Ties keep the lower index.
  - count increments after each accepted sample.
- class_idx and class_score update on the same edge that enters DONE, so they are valid while done=1. They hold until the next pass completes; they are not cleared by start.
- Back-to-back: acc_valid may be high on consecutive cycles; every cycle is accepted, with no backpressure.
- Final sample: its act_valid fires in the same cycle as done.
- A start pulse arriving in the DONE cycle is ignored. start in the first IDLE cycle after DONE is accepted.
- Reset asserted mid-pass: the pass is abandoned and class_idx/class_score return to 0.

Test Plan:
- Reset then idle: rst low 3 cycles, acc_valid pulses with no start -> all outputs stay 0; no act_valid.
- Activation mapping, one pass with acc_data = -500, 0, 127, 128, 16383, 16384, 2097151 (then 3 pads of 0) -> act_data = 0, 0, 0, 1, 127, 127, 127.
- Argmax with tie: sums {5,-3,900,12,900,-1,0,899,7,2} back-to-back -> done one cycle after the 10th sample's acceptance edge; class_idx=2, class_score=900.
- All negative: sums {-10,-4,-9,-4,-20,-30,-5,-6,-7,-8} -> class_idx=1, class_score=-4; all act_data=0.
- Gapped valids: same 10 sums with 0-3 idle cycles between samples, plus a start pulse mid-pass -> same result as the back-to-back run; the extra start is ignored; busy stays high until after done.
- Reset mid-pass: rst low after 4 samples -> outputs 0 asynchronously. A new start and 10 samples then give a correct fresh result; the aborted samples do not leak into it.
